// File: rtl/demux_edge_counter.sv
// Four-channel rising-edge counter with clear-on-read port and sticky overflow flags.
// Build option: define CNT_SATURATE_EN to saturate counters at all-ones instead of wrapping.

module dec_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_y,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_y_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_rise;
  logic             w_at_max;

  assign w_rise   = i_y & ~r_y_q;
  assign w_at_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q <= 1'b0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_y_q <= i_y;
      // A read clears the lane, but an event landing on the same edge starts the new count.
      if (i_clr) begin
        r_cnt <= w_rise ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        r_ovf <= 1'b0;
      end else if (w_rise) begin
        if (w_at_max) begin
          r_ovf <= 1'b1;
`ifdef CNT_SATURATE_EN
          r_cnt <= CNT_MAX;
`else
          r_cnt <= '0;
`endif
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;
endmodule

module demux_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  input  logic             y3,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [3:0]       ovf
);
  localparam int NUM_LANES = 4;
  localparam int STAGES    = 1;

  logic [NUM_LANES-1:0]            w_y;
  logic [NUM_LANES-1:0]            w_clr;
  logic [NUM_LANES-1:0]            w_ovf;
  logic [NUM_LANES-1:0][CNT_W-1:0] w_cnt;
  logic [STAGES:1]                 vld_pipe;
  logic [CNT_W-1:0]                r_rd_data;

  assign w_y = {y3, y2, y1, y0};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_clr[gi] = rd_en && (rd_sel == gi[1:0]);
      dec_lane #(.CNT_W(CNT_W)) u_lane (
        .clk   (clk),
        .rst   (rst),
        .i_y   (w_y[gi]),
        .i_clr (w_clr[gi]),
        .o_cnt (w_cnt[gi]),
        .o_ovf (w_ovf[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      r_rd_data <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
      // Captures the pre-edge count; the lane clears on this same edge.
      if (rd_en) r_rd_data <= w_cnt[rd_sel];
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = vld_pipe[STAGES];
  assign ovf      = w_ovf;
endmodule

// File: tb/tb_demux_edge_counter.sv
// Randomized and directed bench for demux_edge_counter against a count-table reference model.
module tb_demux_edge_counter;
  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;
`ifdef CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             y0, y1, y2, y3;
  logic             rd_en;
  logic [1:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic [3:0]       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  int       mcnt [4];
  bit       mov  [4];
  bit [3:0] mprev;
  int       exp_data;
  bit       exp_valid;

  demux_edge_counter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_valid(rd_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_ovf();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mov[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin mcnt[i] = 0; mov[i] = 0; end
    mprev = '0; exp_data = 0; exp_valid = 0;
  endtask

  // One clock: drive, wait for the edge, advance the model, compare.
  task automatic cyc(input logic [3:0] y, input logic en, input logic [1:0] sel);
    bit rise;
    {y3, y2, y1, y0} = y; rd_en = en; rd_sel = sel;
    @(posedge clk); #1;
    if (en) exp_data = mcnt[sel];
    exp_valid = en;
    for (int i = 0; i < 4; i++) begin
      rise = y[i] && !mprev[i];
      if (en && sel == i) begin
        mcnt[i] = rise ? 1 : 0;
        mov[i]  = 0;
      end else if (rise) begin
        if (mcnt[i] == MAXV) begin
          mov[i]  = 1;
          mcnt[i] = SAT ? MAXV : 0;
        end else mcnt[i] = mcnt[i] + 1;
      end
    end
    mprev = y;
    chk("rd_valid", rd_valid, exp_valid);
    chk("rd_data", rd_data, exp_data);
    chk("ovf", ovf, exp_ovf());
  endtask

  task automatic pulse(input logic [3:0] m);
    cyc(m, 1'b0, 2'd0);
    cyc(4'b0, 1'b0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] sel);
    cyc(4'b0, 1'b1, sel);
  endtask

  initial begin
    rst = 1'b1; {y3, y2, y1, y0} = '0; rd_en = 1'b0; rd_sel = '0;
    model_reset();
    #12;
    chk("rst_data", rd_data, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    cyc(4'b0, 1'b0, 2'd0);

    // three pulses on y2, read twice
    repeat (3) pulse(4'b0100);
    rd(2'd2);
    chk("ch2_first", rd_data, 3);
    rd(2'd2);
    chk("ch2_second", rd_data, 0);
    cyc(4'b0, 1'b0, 2'd0);
    chk("valid_drop", rd_valid, 0);
    chk("data_hold", rd_data, 0);

    // y0/y3 pulsed together, y1 held high
    for (int k = 0; k < 10; k++) cyc({k[0] == 1'b0, 1'b0, 1'b1, k[0] == 1'b0}, 1'b0, 2'd0);
    cyc(4'b0, 1'b0, 2'd0);
    rd(2'd0); chk("sim_ch0", rd_data, 5);
    rd(2'd3); chk("sim_ch3", rd_data, 5);
    rd(2'd1); chk("held_ch1", rd_data, 1);
    rd(2'd2); chk("sim_ch2", rd_data, 0);

    // 256 pulses on y1: overflow
    repeat (256) pulse(4'b0010);
    chk("ovf1_set", ovf[1], 1);
    rd(2'd1);
    chk("ovf_data", rd_data, SAT ? MAXV : 0);
    cyc(4'b0, 1'b0, 2'd0);
    chk("ovf1_clr", ovf[1], 0);

    // read coinciding with an event on the read channel
    repeat (4) pulse(4'b0001);
    cyc(4'b0001, 1'b1, 2'd0);
    chk("coinc_data", rd_data, 4);
    cyc(4'b0, 1'b1, 2'd0);
    chk("coinc_after", rd_data, 1);

    // demux sweep, d=1 then d=0
    for (int d = 1; d >= 0; d--) begin
      for (int s = 0; s < 4; s++) pulse(d[0] ? (4'b0001 << s) : 4'b0000);
      for (int s = 0; s < 4; s++) begin
        rd(s[1:0]);
        chk("sweep", rd_data, d);
      end
    end

    // random traffic, biased toward sparse reads
    for (int k = 0; k < 400; k++)
      cyc(4'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom));
    for (int s = 0; s < 4; s++) rd(s[1:0]);
    cyc(4'b0, 1'b0, 2'd0);

    // async reset mid-operation with a read pending
    repeat (3) pulse(4'b1000);
    rd(2'd3);
    chk("pre_rst_data", rd_data, 3);
    repeat (7) pulse(4'b1000);
    rd_en = 1'b1; rd_sel = 2'd3;
    #2 rst = 1'b1;
    #1;
    chk("arst_data", rd_data, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_ovf", ovf, 0);
    rd_en = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("in_rst_valid", rd_valid, 0);
    end
    y1 = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    cyc(4'b0010, 1'b0, 2'd0);
    chk("no_pulse", rd_valid, 0);
    cyc(4'b0010, 1'b1, 2'd3);
    chk("post_rst_ch3", rd_data, 0);
    cyc(4'b0010, 1'b1, 2'd1);
    chk("high_at_release", rd_data, 1);
    cyc(4'b0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_edge_counter.md
DEMUX_EDGE_COUNTER -- requirements
Module: demux_edge_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each per-channel counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports y0, y1, y2, y3, input, 1 each: channel inputs, one per 1x4 demux output, synchronous to clk.
REQ-005 SHALL have port rd_en, input, 1: read request, sampled each clk edge.
REQ-006 SHALL have port rd_sel, input, 2: channel to read (0..3 maps to y0..y3).
REQ-007 SHALL have port rd_data, output, CNT_W: count of the channel read.
REQ-008 SHALL have port rd_valid, output, 1: rd_data is valid this cycle.
REQ-009 SHALL have port ovf, output, 4: sticky per-channel overflow flags, bit i for yi.

Function
REQ-010 SHALL register each yi into yi_q every clk edge; a rising event on channel i is yi=1 and yi_q=0 at the sampling edge.
REQ-011 SHALL increment cnt[i] by 1 at the same edge where its rising event is sampled; the new value is visible after that edge.
REQ-012 SHALL treat each channel independently; events on any combination of the 4 channels at the same edge SHALL all be counted.
REQ-013 SHALL, on rd_en=1 at edge N, drive rd_data = cnt[rd_sel] as it was before edge N and rd_valid=1 for exactly the cycle after edge N.
REQ-014 SHALL drive rd_valid=0 in any cycle following an edge with rd_en=0; rd_data SHALL hold its last value while rd_valid=0.
REQ-015 SHALL clear cnt[rd_sel] and ovf[rd_sel] at the read edge (clear-on-read).
REQ-016 SHALL, if a rising event on the read channel coincides with its read, return the pre-edge value and leave cnt = 1 with ovf = 0; no event SHALL be lost.
REQ-017 SHALL accept back-to-back reads on consecutive cycles, one result per cycle, with latency 1 each.
REQ-018 SHALL set ovf[i] when an event arrives while cnt[i] = 2^CNT_W-1; ovf[i] SHALL stay set until read of channel i or reset.
REQ-019 SHALL treat a held-high input as a single event; count only 0->1 transitions.

Reset
REQ-020 SHALL, while rst=1, force cnt[0..3]=0, yi_q=0, ovf=0, rd_data=0, rd_valid=0, independent of clk.
REQ-021 SHALL, on rst assertion mid-operation, discard any pending read and all counts with no rd_valid pulse afterward.
REQ-022 SHALL, because yi_q resets to 0, count an input already high at reset release as one event at the first active edge.

Configuration
REQ-023 SHALL support macro CNT_SATURATE_EN selecting overflow behaviour.
REQ-024 SHALL, with CNT_SATURATE_EN defined, hold cnt[i] at 2^CNT_W-1 on overflow events (ovf[i] set).
REQ-025 SHALL, with CNT_SATURATE_EN undefined, wrap cnt[i] from 2^CNT_W-1 to 0 on overflow events (ovf[i] set).

Verification
REQ-026 Bench SHALL cover: 3 pulses on y2, then rd_en=1 rd_sel=2 -> next cycle rd_valid=1 rd_data=3; a second read of ch2 returns 0.
REQ-027 Bench SHALL cover: y0 and y3 pulsed at the same edge 5 times, y1 held high 10 cycles -> reads give ch0=5, ch3=5, ch1=1, ch2=0.
REQ-028 Bench SHALL cover: 256 pulses on y1 (CNT_W=8) -> without macro rd_data=0 and ovf[1]=1; with CNT_SATURATE_EN rd_data=255 and ovf[1]=1; ovf[1]=0 after the read.
REQ-029 Bench SHALL cover: read of ch0 at count 4 coinciding with a y0 rising event -> rd_data=4, subsequent read returns 1.
REQ-030 Bench SHALL cover: rst asserted between clk edges after 7 events on y3 with rd_en=1 pending -> outputs 0 immediately, no rd_valid pulse, post-reset read of ch3 returns 0 (y3 low).
REQ-031 Bench SHALL cover: sweep demux select 0..3 with d=1 then d=0, reading all channels each pass -> each channel counts exactly 1 per d=1 pass, 0 per d=0 pass.
